// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit scheduler: FSM state encoding
// and the default frame width.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_MSG_SIZE = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request found scanning
// upward from last+1, wrapping modulo NUM_REQ. Output is one-hot or zero.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        grant = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one MSB-first serial line among NUM_REQ producers: arbitrate in IDLE,
// shift the latched frame in SHIFT, then hold the line quiet for GAP_CYCLES.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int MSG_SIZE   = DEFAULT_MSG_SIZE,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iEn,
    input  logic [NUM_REQ-1:0]          iReq,
    input  logic [NUM_REQ*MSG_SIZE-1:0] iCiphertext_bus,
    output logic [NUM_REQ-1:0]          oGrant,
    output logic [NUM_REQ-1:0]          oDone,
    output logic                        oSerial_out,
    output logic                        oSerial_flag,
    output logic                        oBusy,
    output state_t                      oState
);

    localparam int BIT_W = $clog2(MSG_SIZE);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: a requester raises iReq with its data valid and holds both
    // until its own oDone pulse; data is captured only in the arbitration cycle.
    state_t              state, state_next;
    logic [MSG_SIZE-1:0] shreg, win_data;
    logic [BIT_W-1:0]    bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [PTR_W-1:0]    last, win_idx;
    logic [NUM_REQ-1:0]  win;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (iReq),
        .last  (last),
        .grant (win)
    );

    always_comb begin
        win_data = '0;
        win_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win[k]) begin
                win_data = iCiphertext_bus[k*MSG_SIZE +: MSG_SIZE];
                win_idx  = PTR_W'(k);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (iEn && |win)             state_next = ST_SHIFT;
            ST_SHIFT: if (iEn && bit_cnt == '0)    state_next = ST_GAP;
            ST_GAP:   if (iEn && gap_cnt == '0)    state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    // oDone defaults low every cycle so the pulse ends even while stalled.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            last    <= PTR_W'(NUM_REQ - 1);
            oGrant  <= '0;
            oDone   <= '0;
        end else begin
            oDone <= '0;
            if (iEn) begin
                case (state)
                    ST_IDLE: begin
                        if (|win) begin
                            shreg   <= win_data;
                            oGrant  <= win;
                            last    <= win_idx;
                            bit_cnt <= BIT_W'(MSG_SIZE - 1);
                        end
                    end
                    ST_SHIFT: begin
                        shreg <= shreg << 1;
                        if (bit_cnt == '0) begin
                            oGrant  <= '0;
                            oDone   <= oGrant;
                            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign oSerial_flag = (state == ST_SHIFT);
    assign oSerial_out  = oSerial_flag & shreg[MSG_SIZE-1];
    assign oBusy        = (state != ST_IDLE);
    assign oState       = state;

endmodule
